mem_stage: RTL and testbench

- MEM stage of the 5-stage RV32I pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes its memory-control, address, store-data and funct3 outputs.
- Runs a valid/ready request plus response transaction to data memory, which may take several cycles.
- Performs byte-lane alignment for stores and extraction/extension for loads.
- Asserts a stall request to the hazard unit while an access is in flight.

---
 rtl/mem_stage_pkg.sv | 40 ++++
 rtl/mem_stage_if.sv | 24 ++
 rtl/mem_lane_align.sv | 55 +++++
 rtl/mem_stage.sv | 146 ++++++++++++++
 tb/tb_mem_stage.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: funct3 encodings, FSM states,
// access-size decode.
package mem_stage_pkg;

    // Load encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    // Store encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_e;

    // Access size from funct3; the unused encodings (011/110/111) fall into word.
    function automatic acc_size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LBU: return SZ_BYTE;
            F3_LH, F3_LHU: return SZ_HALF;
            default:       return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the MEM stage (master) and memory (slave).
interface mem_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_wstrb;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wstrb, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wstrb, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store strobes/replicated data and load extract/extend.
// Offset bits that do not matter for the access size are ignored here.
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] rs2_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_o
);
    acc_size_e   sz;
    logic        uns;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign sz  = f3_size(funct3_i);
    assign uns = funct3_i[2];

    // Pick the addressed byte and halfword out of the read word
    always_comb begin
        byte_sel = rdata_i[7:0];
        case (off_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
            default: byte_sel = rdata_i[7:0];
        endcase
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Size-dependent strobes, store replication and load extension
    always_comb begin
        wstrb_o = 4'b1111;
        wdata_o = rs2_i;
        load_o  = rdata_i;
        case (sz)
            SZ_BYTE: begin
                wstrb_o = 4'b0001 << off_i;
                wdata_o = {4{rs2_i[7:0]}};
                load_o  = {{24{~uns & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                wstrb_o = off_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{rs2_i[15:0]}};
                load_o  = {{16{~uns & half_sel[15]}}, half_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the RV32I pipeline: runs one data-memory transaction per
// load/store and stalls upstream while it is in flight.
// Optional build macro MEM_MISALIGN_CHECK_EN: misaligned half/word accesses
// skip the memory and complete at once with misalign_exc.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read_mem,
    input  logic              mem_write_mem,
    input  logic [2:0]        instr_funct3_mem,
    input  logic [ADDR_W-1:0] alu_result_mem,
    input  logic [DATA_W-1:0] rs2_data_mem,
    mem_stage_if.master       dmem,
    output logic [DATA_W-1:0] load_data_mem,
    output logic              access_done,
    output logic              stall_req,
    output logic              misalign_exc
);
    mem_state_e        state_q;
    logic              is_load_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic              req_valid_q;
    logic              req_we_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [3:0]        req_wstrb_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic [DATA_W-1:0] load_q;
    logic              done_q;
    logic              misal_q;

    logic              access;
    logic              misal_det;
    logic [2:0]        al_f3;
    logic [1:0]        al_off;
    logic [3:0]        wstrb_d;
    logic [DATA_W-1:0] wdata_d;
    logic [DATA_W-1:0] load_d;

    assign access = mem_read_mem | mem_write_mem;

`ifdef MEM_MISALIGN_CHECK_EN
    acc_size_e in_sz;
    assign in_sz     = f3_size(instr_funct3_mem);
    assign misal_det = ((in_sz == SZ_HALF) && alu_result_mem[0]) ||
                       ((in_sz == SZ_WORD) && (alu_result_mem[1:0] != 2'b00));
`else
    assign misal_det = 1'b0;
`endif

    // Store lanes come from the live inputs in IDLE; load extraction uses the captured fields
    assign al_f3  = (state_q == ST_IDLE) ? instr_funct3_mem : f3_q;
    assign al_off = (state_q == ST_IDLE) ? alu_result_mem[1:0] : off_q;

    mem_lane_align u_align (
        .funct3_i (al_f3),
        .off_i    (al_off),
        .rs2_i    (rs2_data_mem),
        .rdata_i  (dmem.rsp_rdata),
        .wstrb_o  (wstrb_d),
        .wdata_o  (wdata_d),
        .load_o   (load_d)
    );

    // Access FSM with registered request and completion outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            is_load_q   <= 1'b0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wstrb_q <= 4'b0000;
            req_wdata_q <= '0;
            load_q      <= '0;
            done_q      <= 1'b0;
            misal_q     <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            misal_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (access) begin
                        // A simultaneous read and write is a load
                        is_load_q <= mem_read_mem;
                        f3_q      <= instr_funct3_mem;
                        off_q     <= alu_result_mem[1:0];
                        if (misal_det) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            misal_q <= 1'b1;
                            if (mem_read_mem) load_q <= ZERO_WORD;
                        end else begin
                            state_q     <= ST_REQ;
                            req_valid_q <= 1'b1;
                            req_we_q    <= ~mem_read_mem;
                            req_addr_q  <= {alu_result_mem[ADDR_W-1:2], 2'b00};
                            req_wstrb_q <= mem_read_mem ? 4'b0000 : wstrb_d;
                            req_wdata_q <= mem_read_mem ? ZERO_WORD : wdata_d;
                        end
                    end
                end
                ST_REQ: begin
                    if (dmem.req_ready) begin
                        req_valid_q <= 1'b0;
                        if (is_load_q) begin
                            state_q <= ST_WAIT;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dmem.rsp_valid) begin
                        load_q  <= load_d;
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stall_req = ((state_q == ST_IDLE) && access) ||
                       (state_q == ST_REQ) || (state_q == ST_WAIT);

    assign dmem.req_valid = req_valid_q;
    assign dmem.req_we    = req_we_q;
    assign dmem.req_addr  = req_addr_q;
    assign dmem.req_wstrb = req_wstrb_q;
    assign dmem.req_wdata = req_wdata_q;
    assign load_data_mem  = load_q;
    assign access_done    = done_q;
    assign misalign_exc   = misal_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed accesses push expected request and
// completion records; monitors pop and compare on handshake / access_done.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [2:0]  f3;
    logic [31:0] addr, rs2;
    logic [31:0] load_data;
    logic        access_done, stall_req, misalign_exc;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0] load;
        logic        misal;
    } rsp_t;

    req_t exp_req_q[$];
    rsp_t exp_rsp_q[$];
    logic [31:0] last_load = 32'h0;

    mem_stage_if dmem_if ();

    mem_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mem_read_mem     (mem_read),
        .mem_write_mem    (mem_write),
        .instr_funct3_mem (f3),
        .alu_result_mem   (addr),
        .rs2_data_mem     (rs2),
        .dmem             (dmem_if.master),
        .load_data_mem    (load_data),
        .access_done      (access_done),
        .stall_req        (stall_req),
        .misalign_exc     (misalign_exc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic tb_misal(input logic [2:0] fn, input logic [31:0] a);
`ifdef MEM_MISALIGN_CHECK_EN
        case (fn)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return a[0];
            default:        return a[1:0] != 2'b00;
        endcase
`else
        return 1'b0;
`endif
    endfunction

    // Request monitor: every accepted request must match the next expected one
    always @(negedge clk) begin
        if (rst_n && dmem_if.req_valid && dmem_if.req_ready) begin
            if (exp_req_q.size() == 0) begin
                total++; bad++;
                $display("FAIL req_unexpected: got addr %h expected none", dmem_if.req_addr);
            end else begin
                req_t e;
                e = exp_req_q.pop_front();
                chk("req_we",    {31'b0, dmem_if.req_we}, {31'b0, e.we});
                chk("req_addr",  dmem_if.req_addr, e.addr);
                chk("req_wstrb", {28'b0, dmem_if.req_wstrb}, {28'b0, e.strb});
                if (e.we) chk("req_wdata", dmem_if.req_wdata, e.wdata);
            end
        end
    end

    // Completion monitor: load result and misalign flag on each access_done
    always @(negedge clk) begin
        if (rst_n && access_done) begin
            if (exp_rsp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL done_unexpected: got access_done 1 expected 0");
            end else begin
                rsp_t e;
                e = exp_rsp_q.pop_front();
                chk("load_data", load_data, e.load);
                chk("misalign_exc", {31'b0, misalign_exc}, {31'b0, e.misal});
            end
        end
    end

    task automatic run_acc(input logic rd, input logic wr, input logic [2:0] fn,
                           input logic [31:0] a, input logic [31:0] d, input int rdy_dly,
                           input logic [31:0] rdata, input logic [31:0] exp_load,
                           input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
        logic mis;
        int   held, cyc;
        bit   hs;
        mis = tb_misal(fn, a);
        if (!mis) exp_req_q.push_back('{we: ~rd, addr: {a[31:2], 2'b00}, strb: exp_strb, wdata: exp_wdata});
        if (rd) last_load = mis ? 32'h0 : exp_load;
        exp_rsp_q.push_back('{load: last_load, misal: mis});

        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; f3 = fn; addr = a; rs2 = d;
        dmem_if.req_ready = 1'b0;
        @(negedge clk);
        chk("stall_idle", {31'b0, stall_req}, 32'd1);

        if (mis) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("mis_no_req", {31'b0, dmem_if.req_valid}, 32'd0);
            chk("mis_done",   {31'b0, access_done}, 32'd1);
            chk("stall_done", {31'b0, stall_req}, 32'd0);
        end else begin
            held = 0; hs = 0; cyc = 0;
            while (!hs && cyc < 20) begin
                @(posedge clk); #1;
                cyc++;
                dmem_if.req_ready = (held >= rdy_dly);
                @(negedge clk);
                chk("req_valid",     {31'b0, dmem_if.req_valid}, 32'd1);
                chk("stall_req",     {31'b0, stall_req}, 32'd1);
                chk("req_addr_hold", dmem_if.req_addr, {a[31:2], 2'b00});
                chk("req_strb_hold", {28'b0, dmem_if.req_wstrb}, {28'b0, exp_strb});
                hs = dmem_if.req_ready;
                held++;
            end
            @(posedge clk); #1;
            dmem_if.req_ready = 1'b0;
            if (rd) begin
                dmem_if.rsp_valid = 1'b1;
                dmem_if.rsp_rdata = rdata;
                @(negedge clk);
                chk("stall_wait", {31'b0, stall_req}, 32'd1);
                chk("no_early_done", {31'b0, access_done}, 32'd0);
                @(posedge clk); #1;
                dmem_if.rsp_valid = 1'b0;
                dmem_if.rsp_rdata = 32'h0;
            end
            @(negedge clk);
            chk("done_pulse", {31'b0, access_done}, 32'd1);
            chk("stall_done", {31'b0, stall_req}, 32'd0);
            chk("valid_drop", {31'b0, dmem_if.req_valid}, 32'd0);
        end
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", {31'b0, access_done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; f3 = 3'b000; addr = 32'h0; rs2 = 32'h0;
        dmem_if.req_ready = 1'b0; dmem_if.rsp_valid = 1'b0; dmem_if.rsp_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'b0, dmem_if.req_valid}, 32'd0);
        chk("rst_we",    {31'b0, dmem_if.req_we}, 32'd0);
        chk("rst_addr",  dmem_if.req_addr, 32'h0);
        chk("rst_wstrb", {28'b0, dmem_if.req_wstrb}, 32'h0);
        chk("rst_wdata", dmem_if.req_wdata, 32'h0);
        chk("rst_load",  load_data, 32'h0);
        chk("rst_done",  {31'b0, access_done}, 32'd0);
        chk("rst_mis",   {31'b0, misalign_exc}, 32'd0);
        chk("rst_stall", {31'b0, stall_req}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        //       rd  wr  f3      addr          rs2           rdy rdata         exp_load      strb     wdata
        run_acc(1, 0, 3'b000, 32'h0000_0103, 32'h0,        0, 32'h80FF_1234, 32'hFFFF_FF80, 4'b0000, 32'h0);
        run_acc(1, 0, 3'b101, 32'h0000_0102, 32'h0,        0, 32'h8765_4321, 32'h0000_8765, 4'b0000, 32'h0);
        run_acc(0, 1, 3'b000, 32'h0000_0201, 32'hAABB_CCDD, 3, 32'h0,        32'h0,         4'b0010, 32'hDDDD_DDDD);
        run_acc(1, 1, 3'b010, 32'h0000_0300, 32'h1111_2222, 1, 32'h1234_5678, 32'h1234_5678, 4'b0000, 32'h0);
        run_acc(0, 1, 3'b001, 32'h0000_0302, 32'h1234_ABCD, 0, 32'h0,        32'h0,         4'b1100, 32'hABCD_ABCD);
        run_acc(1, 0, 3'b001, 32'h0000_0100, 32'h0,        0, 32'h0000_F00F, 32'hFFFF_F00F, 4'b0000, 32'h0);
        run_acc(1, 0, 3'b100, 32'h0000_0101, 32'h0,        0, 32'h0000_9A00, 32'h0000_009A, 4'b0000, 32'h0);
        run_acc(1, 0, 3'b011, 32'h0000_0004, 32'h0,        2, 32'h0102_0304, 32'h0102_0304, 4'b0000, 32'h0);
        run_acc(0, 1, 3'b110, 32'h0000_0008, 32'hFEED_F00D, 0, 32'h0,        32'h0,         4'b1111, 32'hFEED_F00D);
        // Misaligned word load and halfword store: trapped with the check, masked without
        run_acc(1, 0, 3'b010, 32'h0000_0002, 32'h0,        0, 32'hCAFE_BABE, 32'hCAFE_BABE, 4'b0000, 32'h0);
        run_acc(0, 1, 3'b001, 32'h0000_0301, 32'h0000_5A5A, 0, 32'h0,        32'h0,         4'b0011, 32'h5A5A_5A5A);
        run_acc(1, 0, 3'b000, 32'h0000_0010, 32'h0,        0, 32'h0000_0077, 32'h0000_0077, 4'b0000, 32'h0);

        // Reset while a load waits for its response
        exp_req_q.push_back('{we: 1'b0, addr: 32'h0000_0400, strb: 4'b0000, wdata: 32'h0});
        @(posedge clk); #1;
        mem_read = 1'b1; f3 = 3'b010; addr = 32'h0000_0400; dmem_if.req_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        dmem_if.req_ready = 1'b0;
        @(negedge clk);
        chk("wait_stall", {31'b0, stall_req}, 32'd1);
        rst_n = 1'b0; mem_read = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_valid", {31'b0, dmem_if.req_valid}, 32'd0);
        chk("rst_mid_stall", {31'b0, stall_req}, 32'd0);
        chk("rst_mid_load",  load_data, 32'h0);
        chk("rst_mid_done",  {31'b0, access_done}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dmem_if.rsp_valid = 1'b1; dmem_if.rsp_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        dmem_if.rsp_valid = 1'b0;
        @(negedge clk);
        chk("late_rsp_done",  {31'b0, access_done}, 32'd0);
        chk("late_rsp_load",  load_data, 32'h0);
        chk("late_rsp_valid", {31'b0, dmem_if.req_valid}, 32'd0);
        last_load = 32'h0;

        // Recovery after reset
        run_acc(1, 0, 3'b010, 32'h0000_0404, 32'h0, 0, 32'h55AA_55AA, 32'h55AA_55AA, 4'b0000, 32'h0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("req_q_empty", exp_req_q.size(), 32'd0);
        chk("rsp_q_empty", exp_rsp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
